// File: rtl/pcm_pkg.sv
//==============================================================================
// Module      : pcm_pkg
// Description : Shared FSM states and PCM/Q-format constants for the stereo
//               PCM packer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pcm_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MUL   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    localparam int PCM_MAX = 32767;
    localparam int PCM_MIN = -32768;
    localparam int Q10_ONE = 1024;
    localparam int Q14_ONE = 16384;

endpackage

`default_nettype wire

// File: rtl/pcm_sat_lane.sv
//==============================================================================
// Module      : pcm_sat_lane
// Description : One audio lane: signed 32x32 multiply by the Q10 volume,
//               arithmetic rescale, saturation to a PCM_W-bit signed sample.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pcm_sat_lane #(
    parameter int VOL_FRAC  = 10,
    parameter int OUT_SHIFT = 0,
    parameter int PCM_W     = 16
) (
    input  logic [31:0]      sample,
    input  logic [31:0]      volume,
    output logic [PCM_W-1:0] pcm,
    output logic             clipped
);

    localparam logic signed [63:0] c_max = (64'sd1 <<< (PCM_W - 1)) - 64'sd1;
    localparam logic signed [63:0] c_min = -(64'sd1 <<< (PCM_W - 1));

    logic signed [63:0] w_prod;
    logic signed [63:0] w_q;

    assign w_prod = $signed({{32{sample[31]}}, sample}) * $signed({{32{volume[31]}}, volume});
    // Both shifts are arithmetic so the result floors toward -inf.
    assign w_q    = (w_prod >>> VOL_FRAC) >>> OUT_SHIFT;

    always_comb begin
        pcm     = w_q[PCM_W-1:0];
        clipped = 1'b0;
        if (w_q > c_max) begin
            pcm     = c_max[PCM_W-1:0];
            clipped = 1'b1;
        end else if (w_q < c_min) begin
            pcm     = c_min[PCM_W-1:0];
            clipped = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pcm_pack_stereo.sv
//==============================================================================
// Module      : pcm_pack_stereo
// Description : Pops one left/right Q14 pair, applies a Q10 volume, saturates
//               each lane to PCM and pushes {left,right} to the output FIFO.
//               Define PCM_CLIP_CNT_EN to add the sticky clip_count port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pcm_pack_stereo
    import pcm_pkg::*;
#(
    parameter int VOL_FRAC  = 10,
    parameter int OUT_SHIFT = 0,
    parameter int PCM_W     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          volume,
    input  logic                 left_empty,
    input  logic [31:0]          left_dout,
    output logic                 left_rd_en,
    input  logic                 right_empty,
    input  logic [31:0]          right_dout,
    output logic                 right_rd_en,
    input  logic                 out_full,
    output logic                 out_wr_en,
`ifdef PCM_CLIP_CNT_EN
    output logic [15:0]          clip_count,
`endif
    output logic [2*PCM_W-1:0]   out_din
);

    state_t             r_state;
    logic [31:0]        r_left;
    logic [31:0]        r_right;
    logic [31:0]        r_vol;
    logic [PCM_W-1:0]   w_pcm_l;
    logic [PCM_W-1:0]   w_pcm_r;
    logic               w_clip_l;
    logic               w_clip_r;
    logic               w_pop;
    logic               w_push;

    // Gated by reset so a frame in flight is never pushed and nothing is popped while held.
    assign w_pop       = !reset && (r_state == S_IDLE) && !left_empty && !right_empty;
    assign w_push      = !reset && (r_state == S_WRITE) && !out_full;
    assign left_rd_en  = w_pop;
    assign right_rd_en = w_pop;
    assign out_wr_en   = w_push;

    pcm_sat_lane #(
        .VOL_FRAC  (VOL_FRAC),
        .OUT_SHIFT (OUT_SHIFT),
        .PCM_W     (PCM_W)
    ) u_lane_l (
        .sample  (r_left),
        .volume  (r_vol),
        .pcm     (w_pcm_l),
        .clipped (w_clip_l)
    );

    pcm_sat_lane #(
        .VOL_FRAC  (VOL_FRAC),
        .OUT_SHIFT (OUT_SHIFT),
        .PCM_W     (PCM_W)
    ) u_lane_r (
        .sample  (r_right),
        .volume  (r_vol),
        .pcm     (w_pcm_r),
        .clipped (w_clip_r)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_left  <= '0;
            r_right <= '0;
            r_vol   <= '0;
            out_din <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_left  <= left_dout;
                        r_right <= right_dout;
                        r_vol   <= volume;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    out_din <= {w_pcm_l, w_pcm_r};
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (w_push) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PCM_CLIP_CNT_EN
    logic [15:0] r_clip_count;
    logic [16:0] w_clip_sum;

    assign w_clip_sum = {1'b0, r_clip_count} + {16'd0, w_clip_l} + {16'd0, w_clip_r};
    assign clip_count = r_clip_count;

    // Sticks at all-ones; the 17th bit catches the +2 overflow case.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clip_count <= '0;
        end else if (r_state == S_MUL) begin
            r_clip_count <= w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
        end
    end
`else
    logic w_unused_clip;
    assign w_unused_clip = w_clip_l | w_clip_r;
`endif

endmodule

`default_nettype wire

// File: doc/pcm_pack_stereo.md
Name: pcm_pack_stereo

Overview:
Output-side counterpart of the FM demod gain stage. It pops one Q14 sample each from the left and right audio FIFOs and applies a runtime Q10 volume. Each result is rescaled and saturated to signed 16-bit PCM. The pair is packed into one 32-bit word and pushed to the audio-out FIFO. It sits between the de-emphasis/gain chain and the DAC/I2S output FIFO.

Parameters:
VOL_FRAC, 10, fractional bits of the volume operand (Q10).
OUT_SHIFT, 0, arithmetic right shift applied after the volume scaling, before saturation.
PCM_W, 16, width of each packed PCM lane; out_din width = 2*PCM_W.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
volume  in  32  signed Q10 volume; 1024 = unity.
left_empty  in  1  left input FIFO empty.
left_dout  in  32  left sample, signed Q14, first-word-fall-through (FWFT).
left_rd_en  out  1  left FIFO pop.
right_empty  in  1  right input FIFO empty.
right_dout  in  32  right sample, signed Q14, FWFT.
right_rd_en  out  1  right FIFO pop.
out_full  in  1  output FIFO full.
out_wr_en  out  1  output FIFO push.
out_din  out  32  packed word: {left_pcm[15:0], right_pcm[15:0]}.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state = S_IDLE; left_rd_en, right_rd_en, out_wr_en = 0; out_din = 0; all internal registers cleared.
- FSM S_IDLE:
  - If !left_empty && !right_empty: assert left_rd_en and right_rd_en together, combinationally, for exactly one cycle.
  - In that same cycle, register left_dout, right_dout and volume; go to S_MUL.
  - Never pop only one side.
- FSM S_MUL:
  - Compute each lane as a 64-bit signed product: p = $signed(sample) * $signed(volume).
  - q = p >>> VOL_FRAC, then q >>> OUT_SHIFT. Both shifts are arithmetic, so results floor toward -inf.
  - Saturate q to [-32768, 32767] and register the packed word into out_din; go to S_WRITE.
- FSM S_WRITE:
  - out_wr_en = !out_full, combinational.
  - When the push occurs, go to S_IDLE. Otherwise hold state; out_din stays stable.
- Latency: pop to push is 2 cycles when out_full is low. Throughput is one frame per 3 cycles.
- Volume: sampled once per frame at pop. Changes mid-frame take effect on the next frame.
- Negative volume is legal and inverts polarity; saturation still applies.
- Volume = 0 yields 0x00000000.
- Boundary cases:
  - Input FIFOs drain mid-stream: stay in S_IDLE with no pops.
  - out_full held indefinitely: stall in S_WRITE; no further pops, no data loss.
  - Reset asserted in any state: next cycle has all outputs at reset values. A frame already popped is discarded and not written.

Optional Feature:
Macro PCM_CLIP_CNT_EN.
- Defined:
  - Adds output port clip_count (16 bits).
  - Increments by 1 for each lane that saturates in S_MUL (+2 if both lanes clip).
  - Sticks at 0xFFFF; cleared by reset.
- Undefined: port and counter absent; datapath identical.

Decomposition:
- Shared package pcm_pkg:
  - state enum (S_IDLE, S_MUL, S_WRITE);
  - PCM_MAX = 32767 and PCM_MIN = -32768;
  - Q10_ONE = 1024 and Q14_ONE = 16384.
- One natural sub-module, pcm_sat_lane:
  - combinational 32x32 signed multiply, shift and saturate for one lane;
  - instantiated twice (left and right), with a clipped flag out.

Test Plan:
- Unity gain: volume=1024, L=16384, R=-16384 -> out_din=0x4000C000, written 2 cycles after the pop.
- Saturation: volume=2048, L=20000, R=-20000 -> 0x7FFF8000; with PCM_CLIP_CNT_EN, clip_count=2.
- Rounding: volume=512, L=3, R=-3 -> lanes 1 and -2 -> 0x0001FFFE.
- Backpressure: out_full high 5 cycles in S_WRITE -> out_wr_en=0 and out_din stable throughout; no rd_en pulses; push on the first cycle out_full drops.
- Unbalanced input: left non-empty, right empty for 10 cycles -> no rd_en on either side. Then right fills -> single simultaneous pop on both sides.
- Reset in S_WRITE: outputs 0 next cycle, no push of the pending word, and the FSM restarts cleanly on the next available frame.
